// File: rtl/enc_pkg.sv
// Shared types and constants for the 4:2 request encoder.
package enc_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned CODE_W = 2;

    typedef logic [N_REQ-1:0]  req_t;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic {IDLE, PRESENT} state_e;

    // Decoder mapping: code k selects mask bit k.
    function automatic req_t code_to_mask(input code_t code);
        code_to_mask = req_t'(1) << code;
    endfunction

endpackage

// File: rtl/encoder_4x2_req_if.sv
// Request/output bundle of the 4:2 request encoder; master drives requests, slave is the encoder.
interface encoder_4x2_req_if
    import enc_pkg::*;
();

    req_t  req;
    logic  out_ready;
    logic  out_valid;
    code_t out_code;
    req_t  pending;
    logic  ovf;

    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  out_code,
        input  pending,
        input  ovf
    );

    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output out_code,
        output pending,
        output ovf
    );

endinterface

// File: rtl/enc_pick4.sv
// Combinational selector over the pending mask.
// ENC_RR_EN: ascending search from start with wrap; otherwise fixed priority, highest index wins.
module enc_pick4
    import enc_pkg::*;
(
    input  req_t  pending,
    input  code_t start,
    output code_t code,
    output logic  any
);

`ifdef ENC_RR_EN
    code_t idx;

    always_comb begin
        code = '0;
        idx  = '0;
        any  = |pending;
        // Walk offsets from farthest to nearest so the nearest match is assigned last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = start + code_t'(i);
            if (pending[idx]) begin
                code = idx;
            end
        end
    end
`else
    logic unused_start;

    assign unused_start = ^start;

    always_comb begin
        code = '0;
        any  = |pending;
        for (int i = 0; i < N_REQ; i++) begin
            if (pending[i]) begin
                code = code_t'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/encoder_4x2_req.sv
// Latched 4-request encoder presenting one granted index at a time with valid/ready.
// Build macro ENC_RR_EN selects round-robin instead of fixed highest-index priority.
module encoder_4x2_req
    import enc_pkg::*;
(
    input logic               clk,
    input logic               rst,
    encoder_4x2_req_if.slave  bus
);

    state_e state_q, state_d;
    req_t   pending_q, pending_d;
    code_t  code_q, code_d;
    logic   ovf_q, ovf_d;

    code_t  pick_code;
    logic   pick_any;
    code_t  start;
    logic   load;
    req_t   clear_mask;

`ifdef ENC_RR_EN
    code_t ptr_q, ptr_d;

    assign start = ptr_q;
    // Pointer holds the next search start, so a fresh reset begins at index 0.
    assign ptr_d = load ? pick_code + code_t'(1) : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start = '0;
`endif

    enc_pick4 u_pick (
        .pending (pending_q),
        .start   (start),
        .code    (pick_code),
        .any     (pick_any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        code_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
            end
        endcase
        if (load) begin
            code_d = pick_code;
        end

        clear_mask = load ? code_to_mask(pick_code) : '0;
        // Set wins over clear; a request hitting a still-pending bit is merged and flagged.
        pending_d  = (pending_q & ~clear_mask) | bus.req;
        ovf_d      = ovf_q | (|(bus.req & pending_q & ~clear_mask));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.out_valid = (state_q == PRESENT);
    assign bus.out_code  = code_q;
    assign bus.pending   = pending_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_encoder_4x2_req.sv
// Scoreboard bench for encoder_4x2_req: expected codes queued at stimulus, popped on transfers.
module tb_encoder_4x2_req;

    logic clk;
    logic rst;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [1:0]  sb[$];

    encoder_4x2_req_if bus ();

    encoder_4x2_req dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.out_ready = 1'b0;
        sb.delete();
        cyc(1);
        rst = 1'b0;
    endtask

    // Each accepted transfer must match the oldest expected code.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                check_eq("sb_code", 32'(bus.out_code), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        logic [1:0] order [4];
`ifdef ENC_RR_EN
        order = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
        order = '{2'd3, 2'd2, 2'd1, 2'd0};
`endif
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.out_ready = 1'b0;
        cyc(2);
        rst = 1'b0;
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_code", 32'(bus.out_code), 32'd0);
        check_eq("rst_pending", 32'(bus.pending), 32'd0);
        check_eq("rst_ovf", 32'(bus.ovf), 32'd0);

        // Single request, two-edge latency.
        bus.out_ready = 1'b1;
        bus.req = 4'b0100;
        sb.push_back(2'd2);
        cyc(1);
        bus.req = '0;
        check_eq("lat_pending", 32'(bus.pending), 32'h4);
        check_eq("lat_valid_early", 32'(bus.out_valid), 32'd0);
        cyc(1);
        check_eq("lat_valid", 32'(bus.out_valid), 32'd1);
        check_eq("lat_code", 32'(bus.out_code), 32'd2);
        cyc(1);
        check_eq("lat_idle_valid", 32'(bus.out_valid), 32'd0);
        check_eq("lat_idle_pending", 32'(bus.pending), 32'd0);
        check_eq("lat_idle_code", 32'(bus.out_code), 32'd0);

        // All four at once: back-to-back in selection order.
        do_reset();
        bus.out_ready = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) sb.push_back(order[i]);
        cyc(1);
        bus.req = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check_eq("b2b_valid", 32'(bus.out_valid), 32'd1);
            check_eq("b2b_code", 32'(bus.out_code), 32'(order[i]));
        end
        cyc(1);
        check_eq("b2b_end_valid", 32'(bus.out_valid), 32'd0);

        // Stall holds output stable.
        bus.out_ready = 1'b0;
        bus.req = 4'b0001;
        sb.push_back(2'd0);
        cyc(1);
        bus.req = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
            check_eq("stall_code", 32'(bus.out_code), 32'd0);
        end
        bus.out_ready = 1'b1;
        cyc(1);
        check_eq("stall_done_valid", 32'(bus.out_valid), 32'd0);

        // Overflow: repeated req[1] merges while index 3 is stalled.
        bus.out_ready = 1'b0;
        bus.req = 4'b1000;
        sb.push_back(2'd3);
        cyc(1);
        bus.req = '0;
        cyc(1);
        bus.req = 4'b0010;
        sb.push_back(2'd1);
        cyc(1);
        bus.req = '0;
        check_eq("ovf_first", 32'(bus.ovf), 32'd0);
        cyc(1);
        bus.req = 4'b0010;
        cyc(1);
        bus.req = '0;
        cyc(1);
        bus.req = 4'b0010;
        cyc(1);
        bus.req = '0;
        check_eq("ovf_set", 32'(bus.ovf), 32'd1);
        check_eq("ovf_pending", 32'(bus.pending), 32'h2);
        check_eq("ovf_code_held", 32'(bus.out_code), 32'd3);
        bus.out_ready = 1'b1;
        cyc(1);
        check_eq("ovf_next_code", 32'(bus.out_code), 32'd1);
        cyc(1);
        check_eq("ovf_idle_valid", 32'(bus.out_valid), 32'd0);
        check_eq("ovf_sticky", 32'(bus.ovf), 32'd1);

        // Same-cycle re-request of the index being loaded.
        do_reset();
        bus.out_ready = 1'b1;
        bus.req = 4'b0100;
        sb.push_back(2'd2);
        cyc(1);
        sb.push_back(2'd2);
        cyc(1);
        bus.req = '0;
        check_eq("reload_pending", 32'(bus.pending), 32'h4);
        check_eq("reload_code1", 32'(bus.out_code), 32'd2);
        cyc(1);
        check_eq("reload_valid2", 32'(bus.out_valid), 32'd1);
        check_eq("reload_code2", 32'(bus.out_code), 32'd2);
        check_eq("reload_pending2", 32'(bus.pending), 32'd0);
        cyc(1);
        check_eq("reload_idle", 32'(bus.out_valid), 32'd0);
        check_eq("reload_ovf", 32'(bus.ovf), 32'd0);

        // Reset while presenting with work pending.
        do_reset();
        bus.req = 4'b0001;
        sb.push_back(2'd0);
        cyc(1);
        bus.req = 4'b1010;
        cyc(1);
        bus.req = 4'b1000;
        cyc(1);
        bus.req = '0;
        check_eq("mid_pending", 32'(bus.pending), 32'ha);
        check_eq("mid_ovf", 32'(bus.ovf), 32'd1);
        check_eq("mid_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        bus.req = 4'b0100;
        sb.delete();
        cyc(1);
        rst = 1'b0;
        bus.req = '0;
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_pending", 32'(bus.pending), 32'd0);
        check_eq("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        check_eq("mid_rst_code", 32'(bus.out_code), 32'd0);
        bus.out_ready = 1'b1;
        cyc(3);
        check_eq("mid_no_stale", 32'(bus.out_valid), 32'd0);
        check_eq("mid_no_pending", 32'(bus.pending), 32'd0);

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
